// File: rtl/bcd_addsub_seq.sv
// ============================================================================
// Module   : bcd_addsub_seq
// Brief    : Digit-serial BCD adder/subtractor with sign-magnitude result,
//            operand validation and a busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_addsub_seq #(
    parameter int         DIGITS    = 2,
    parameter logic [3:0] SIGN_CODE = 4'd10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_button,
    input  logic                      i_mode,
    input  logic [4*DIGITS-1:0]       i_a_bcd,
    input  logic [4*DIGITS-1:0]       i_b_bcd,
    output logic [4*(DIGITS+1)-1:0]   o_result_bcd,
    output logic [3:0]                o_sign_digit,
    output logic                      o_neg,
    output logic                      o_err,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int              c_IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_COMPUTE = 3'd2,
        S_FIXUP   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_button_q;
    logic [4*DIGITS-1:0]       r_a;
    logic [4*DIGITS-1:0]       r_b;
    logic                      r_mode;
    logic [c_IW-1:0]           r_idx;
    logic                      r_c;
    logic [4*DIGITS-1:0]       r_work;
    logic [4*(DIGITS+1)-1:0]   r_result;
    logic [3:0]                r_sign;
    logic                      r_neg;
    logic                      r_err;

    logic                      w_start;
    logic                      w_bad;
    logic                      w_last;
    logic [3:0]                w_op_a;
    logic [3:0]                w_op_b;
    logic [4:0]                w_sum;
    logic [4:0]                w_diff;
    logic [3:0]                w_digit;
    logic                      w_c_nxt;
    logic [4*DIGITS-1:0]       w_work_nxt;

    assign w_start = i_button & ~r_button_q & (r_state == S_IDLE);
    assign w_last  = (r_idx == c_LAST);

    // Flag any latched operand nibble that is not a valid BCD digit.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((r_a[i*4 +: 4] > 4'd9) || (r_b[i*4 +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    // One-digit BCD add/subtract; FIXUP swaps the operands to form b - a.
    always_comb begin
        w_op_a     = (r_state == S_FIXUP) ? r_b[r_idx*4 +: 4] : r_a[r_idx*4 +: 4];
        w_op_b     = (r_state == S_FIXUP) ? r_a[r_idx*4 +: 4] : r_b[r_idx*4 +: 4];
        w_sum      = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'd0, r_c};
        w_diff     = {1'b0, w_op_a} - {1'b0, w_op_b} - {4'd0, r_c};
        w_digit    = 4'd0;
        w_c_nxt    = 1'b0;
        if (r_mode && (r_state != S_FIXUP)) begin
            if (w_sum > 5'd9) begin
                w_digit = 4'(w_sum - 5'd10);
                w_c_nxt = 1'b1;
            end else begin
                w_digit = w_sum[3:0];
            end
        end else begin
            // Bit 4 set means the 5-bit difference went negative.
            if (w_diff[4]) begin
                w_digit = 4'(w_diff + 5'd10);
                w_c_nxt = 1'b1;
            end else begin
                w_digit = w_diff[3:0];
            end
        end
        w_work_nxt = r_work;
        w_work_nxt[r_idx*4 +: 4] = w_digit;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start) w_state_nxt = S_CHECK;
            S_CHECK:   w_state_nxt = w_bad ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (w_last) w_state_nxt = (!r_mode && w_c_nxt) ? S_FIXUP : S_DONE;
            S_FIXUP:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Button history tracks the input in every state so a held button never retriggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_button_q <= 1'b0;
        end else begin
            r_button_q <= i_button;
        end
    end

    // Operand latch, digit-serial datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_idx    <= '0;
            r_c      <= 1'b0;
            r_work   <= '0;
            r_result <= '0;
            r_sign   <= 4'd0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a    <= i_a_bcd;
                        r_b    <= i_b_bcd;
                        r_mode <= i_mode;
                    end
                end
                S_CHECK: begin
                    r_idx <= '0;
                    r_c   <= 1'b0;
                    if (w_bad) begin
                        r_result <= '0;
                        r_sign   <= 4'd0;
                        r_neg    <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_work <= w_work_nxt;
                    r_c    <= w_c_nxt;
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        if (!r_mode && w_c_nxt) begin
                            // a < b: restart the digit walk for b - a.
                            r_idx <= '0;
                            r_c   <= 1'b0;
                        end else begin
                            r_result <= {3'd0, (r_mode & w_c_nxt), w_work_nxt};
                            r_sign   <= 4'd0;
                            r_neg    <= 1'b0;
                            r_err    <= 1'b0;
                        end
                    end
                end
                S_FIXUP: begin
                    r_work <= w_work_nxt;
                    r_c    <= w_c_nxt;
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        r_result <= {4'd0, w_work_nxt};
                        r_sign   <= SIGN_CODE;
                        r_neg    <= 1'b1;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result_bcd = r_result;
    assign o_sign_digit = r_sign;
    assign o_neg        = r_neg;
    assign o_err        = r_err;
    assign o_busy       = (r_state == S_CHECK) || (r_state == S_COMPUTE) || (r_state == S_FIXUP);
    assign o_done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_addsub_seq.sv
// ============================================================================
// Module   : tb_bcd_addsub_seq
// Brief    : Directed self-checking bench for bcd_addsub_seq (DIGITS=2 and 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        btn2, mode2;
    logic [7:0]  a2, b2;
    logic [11:0] res2;
    logic [3:0]  sign2;
    logic        neg2, err2, busy2, done2;

    logic        btn4, mode4;
    logic [15:0] a4, b4;
    logic [19:0] res4;
    logic [3:0]  sign4;
    logic        neg4, err4, busy4, done4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_addsub_seq #(.DIGITS(2), .SIGN_CODE(4'd10)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_button(btn2), .i_mode(mode2),
        .i_a_bcd(a2), .i_b_bcd(b2), .o_result_bcd(res2), .o_sign_digit(sign2),
        .o_neg(neg2), .o_err(err2), .o_busy(busy2), .o_done(done2)
    );

    bcd_addsub_seq #(.DIGITS(4), .SIGN_CODE(4'd10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_button(btn4), .i_mode(mode4),
        .i_a_bcd(a4), .i_b_bcd(b4), .o_result_bcd(res4), .o_sign_digit(sign4),
        .o_neg(neg4), .o_err(err4), .o_busy(busy4), .o_done(done4)
    );

    // Start one 2-digit operation and watch a fixed window of negedges after the start edge.
    task automatic do_op2(input logic m, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int nbusy, output int ndone);
        @(negedge clk);
        mode2 = m; a2 = a; b2 = b; btn2 = 1'b1;
        @(posedge clk);
        lat = 0; nbusy = 0; ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done2) begin ndone++; if (lat == 0) lat = n; end
            if (busy2) nbusy++;
            if (n == 1) begin btn2 = 1'b0; a2 = 8'hFF; b2 = 8'hFF; mode2 = ~m; end
        end
    endtask

    task automatic do_op4(input logic m, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int ndone);
        @(negedge clk);
        mode4 = m; a4 = a; b4 = b; btn4 = 1'b1;
        @(posedge clk);
        lat = 0; ndone = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (done4) begin ndone++; if (lat == 0) lat = n; end
            if (n == 1) begin btn4 = 1'b0; a4 = 16'hFFFF; b4 = 16'hFFFF; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0;
        btn4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({res2, sign2, neg2, err2, busy2, done2} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_d2 got=%h want=0", {res2, sign2, neg2, err2, busy2, done2});
        end
        n_vec++;
        if ({res4, sign4, neg4, err4, busy4, done4} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_d4 got=%h want=0", {res4, sign4, neg4, err4, busy4, done4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sub;
        int lat, nb, nd;
        // 47 - 23 = 24
        do_op2(1'b0, 8'h47, 8'h23, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h024, 1'b0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL sub_47_23 got=%h/%b/%0d/%b want=024/0/0/0", res2, neg2, sign2, err2);
        end
        n_vec++;
        if (lat !== 4 || nb !== 3 || nd !== 1) begin
            n_err++; $display("FAIL sub_47_23_timing lat=%0d busy=%0d dones=%0d want 4/3/1", lat, nb, nd);
        end
        // 23 - 47 = -24
        do_op2(1'b0, 8'h23, 8'h47, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h024, 1'b1, 4'd10, 1'b0}) begin
            n_err++; $display("FAIL sub_23_47 got=%h/%b/%0d/%b want=024/1/10/0", res2, neg2, sign2, err2);
        end
        n_vec++;
        if (lat !== 6 || nb !== 5 || nd !== 1) begin
            n_err++; $display("FAIL sub_23_47_timing lat=%0d busy=%0d dones=%0d want 6/5/1", lat, nb, nd);
        end
        // 50 - 50 = 0, never negative
        do_op2(1'b0, 8'h50, 8'h50, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h000, 1'b0, 4'd0, 1'b0} || lat !== 4) begin
            n_err++; $display("FAIL sub_50_50 got=%h/%b/%0d lat=%0d want=000/0/0 lat=4", res2, neg2, sign2, lat);
        end
    endtask

    task automatic test_add;
        int lat, nb, nd;
        do_op2(1'b1, 8'h99, 8'h99, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h198, 1'b0, 4'd0, 1'b0} || lat !== 4) begin
            n_err++; $display("FAIL add_99_99 got=%h/%b/%0d lat=%0d want=198/0/0 lat=4", res2, neg2, sign2, lat);
        end
        do_op2(1'b1, 8'h05, 8'h07, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h012, 1'b0, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL add_05_07 got=%h/%b/%0d want=012/0/0", res2, neg2, sign2);
        end
    endtask

    task automatic test_error;
        int lat, nb, nd;
        do_op2(1'b0, 8'h4A, 8'h12, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, sign2, err2} !== {12'h000, 1'b0, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL err_4A got=%h/%b/%0d/%b want=000/0/0/1", res2, neg2, sign2, err2);
        end
        n_vec++;
        if (lat !== 2 || nd !== 1) begin
            n_err++; $display("FAIL err_4A_timing lat=%0d dones=%0d want 2/1", lat, nd);
        end
        do_op2(1'b0, 8'h10, 8'h03, lat, nb, nd);
        n_vec++;
        if ({res2, err2} !== {12'h007, 1'b0}) begin
            n_err++; $display("FAIL err_clear got=%h/%b want=007/0", res2, err2);
        end
    endtask

    task automatic test_held_button;
        int nd;
        @(negedge clk);
        mode2 = 1'b0; a2 = 8'h31; b2 = 8'h12; btn2 = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (done2) nd++;
            if (n == 1) begin btn2 = 1'b0; a2 = 8'h99; b2 = 8'h00; end
            if (n == 2) btn2 = 1'b1;
        end
        n_vec++;
        if (nd !== 1) begin
            n_err++; $display("FAIL held_dones got=%0d want=1", nd);
        end
        n_vec++;
        if ({res2, neg2, busy2} !== {12'h019, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL held_result got=%h/%b/%b want=019/0/0", res2, neg2, busy2);
        end
        btn2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int nd, lat, nb;
        @(negedge clk);
        mode2 = 1'b0; a2 = 8'h23; b2 = 8'h47; btn2 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) btn2 = 1'b0;
        end
        n_vec++;
        if (busy2 !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_busy got=%b want=1", busy2);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({res2, sign2, neg2, err2, busy2, done2} !== 20'h0) begin
            n_err++; $display("FAIL rst_mid_outputs got=%h want=0", {res2, sign2, neg2, err2, busy2, done2});
        end
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done2) nd++;
            if (n == 2) rst_n = 1'b1;
        end
        n_vec++;
        if (nd !== 0 || res2 !== 12'h000) begin
            n_err++; $display("FAIL rst_mid_nodone dones=%0d res=%h want 0/000", nd, res2);
        end
        do_op2(1'b0, 8'h10, 8'h03, lat, nb, nd);
        n_vec++;
        if ({res2, neg2, err2} !== {12'h007, 1'b0, 1'b0} || lat !== 4) begin
            n_err++; $display("FAIL rst_mid_after got=%h/%b/%b lat=%0d want=007/0/0 lat=4", res2, neg2, err2, lat);
        end
    endtask

    task automatic test_digits4;
        int lat, nd;
        do_op4(1'b0, 16'h1000, 16'h0001, lat, nd);
        n_vec++;
        if ({res4, neg4, sign4} !== {20'h00999, 1'b0, 4'd0} || lat !== 6) begin
            n_err++; $display("FAIL d4_1000_0001 got=%h/%b/%0d lat=%0d want=00999/0/0 lat=6", res4, neg4, sign4, lat);
        end
        do_op4(1'b0, 16'h0001, 16'h1000, lat, nd);
        n_vec++;
        if ({res4, neg4, sign4} !== {20'h00999, 1'b1, 4'd10} || lat !== 10) begin
            n_err++; $display("FAIL d4_0001_1000 got=%h/%b/%0d lat=%0d want=00999/1/10 lat=10", res4, neg4, sign4, lat);
        end
        do_op4(1'b1, 16'h9999, 16'h0001, lat, nd);
        n_vec++;
        if ({res4, neg4, err4} !== {20'h10000, 1'b0, 1'b0} || lat !== 6 || nd !== 1) begin
            n_err++; $display("FAIL d4_9999_p_0001 got=%h/%b/%b lat=%0d dones=%0d want=10000/0/0 6/1", res4, neg4, err4, lat, nd);
        end
    endtask

    initial begin
        test_reset;
        test_sub;
        test_add;
        test_error;
        test_held_button;
        test_reset_mid;
        test_digits4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
- Sequential, digit-serial BCD adder/subtractor for the calculator datapath.
- Takes two DIGITS-digit BCD operands from the keypad-entry registers and a mode select. Starts on the rising edge of a debounced operate button.
- Outputs a sign-magnitude BCD result in the display's digit format. Sign digit code 10 means minus.
- Replaces the fixed 2-digit, button-clocked subtractor with a clocked, width-parametrised unit that adds addition, input validation and a busy/done handshake.

Parameters:
- DIGITS, 2, digits per operand (1..8); the result has DIGITS+1 magnitude digits.
- SIGN_CODE, 10, value driven on sign_digit when the result is negative.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state and outputs.
- button  in  1  debounced operate request, level signal; one operation per rising edge.
- mode  in  1  0 = subtract (a - b), 1 = add (a + b); sampled with the operands.
- a_bcd  in  4*DIGITS  operand A, packed BCD, most significant digit in the top nibble.
- b_bcd  in  4*DIGITS  operand B, same format.
- result_bcd  out  4*(DIGITS+1)  magnitude, packed BCD, most significant digit in the top nibble.
- sign_digit  out  4  SIGN_CODE if negative, else 0.
- neg  out  1  result negative.
- err  out  1  last operation had an operand nibble > 9.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (reset=0, async): state IDLE; result_bcd, sign_digit, neg, err, busy, done = 0; button history register = 0.
- Edge detect: button_q registers button. A start is button=1 and button_q=0 sampled in IDLE. Holding button high yields exactly one operation.
- Button edges while not in IDLE are ignored and not queued. button_q still tracks button, so a held button never retriggers.
- States:
  - IDLE: busy=0. On start, latch a_bcd, b_bcd and mode into internal registers; go to CHECK. busy=1 from the next cycle.
  - CHECK (1 cycle): if any latched nibble > 9, set the error flag and go to DONE. Otherwise clear the digit index and carry/borrow; go to COMPUTE.
  - COMPUTE (DIGITS cycles): processes one digit per cycle, least significant digit first.
    - Add: s = a_i + b_i + c. If s > 9, write s - 10 and set c=1; else write s and set c=0.
    - Subtract: d = a_i - b_i - br. If d < 0, write d + 10 and set br=1; else write d and set br=0.
    - After the last digit:
      - Add: top digit = c; go to DONE.
      - Subtract with br=0: top digit = 0; go to DONE.
      - Subtract with br=1: go to FIXUP.
  - FIXUP (DIGITS cycles): recompute the magnitude as b - a with the same digit-serial borrow rule, overwriting the working digits. Set the negative flag; top digit = 0; go to DONE.
  - DONE (1 cycle): drive done=1. result_bcd, neg, sign_digit and err update at the edge entering DONE and hold until the next DONE or reset. Return to IDLE.
- On error, outputs are result_bcd=0, neg=0, sign_digit=0, err=1.
- Latency from the edge sampling the start to done high:
  - error: 2 cycles;
  - add, or subtract with a >= b: DIGITS+2 cycles;
  - subtract with a < b: 2*DIGITS+2 cycles.
- Zero result (a == b, subtract) is never negative: neg=0, sign_digit=0.
- Operand inputs may change after the start edge without effect.
- Reset mid-operation aborts immediately. No done pulse. Outputs read 0.

Test Plan:
- DIGITS=2, mode=0, a=47, b=23 -> result_bcd=0x024, neg=0, sign_digit=0, done exactly 4 cycles after the start edge, busy high for 3 cycles.
- mode=0, a=23, b=47 -> result_bcd=0x024, neg=1, sign_digit=10, done 6 cycles after the start edge; a=50, b=50 -> 0x000, neg=0.
- mode=1, a=99, b=99 -> result_bcd=0x198, neg=0; a=05, b=07 -> 0x012 (checks digit carry).
- a=0x4A, b=0x12 -> err=1, result_bcd=0, done 2 cycles after the start edge. The next valid operation clears err.
- button held high 20 cycles, plus a second rising edge while busy -> exactly one done pulse; outputs unchanged until the next edge in IDLE.
- reset asserted during FIXUP of 23-47 -> all outputs 0 immediately, no done. After release, a new 10-03 gives 0x007.
- DIGITS=4 regression: 1000-0001 -> 0x00999; 0001-1000 -> 0x00999 with neg=1; 9999+0001 -> 0x10000.
